// File: rtl/uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart
//  Purpose  : 8N1 UART with independent transmitter and receiver, a 2-flop
//             rx synchronizer, a 2-entry receive FIFO and sticky error flags.
//  Revision : 1.0  initial release
// ============================================================================
module uart #(
  parameter int CLK_FREQ = 125_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ack,
  output logic       err_frame,
  output logic       err_overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Transmitter state
  state_t           tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_shift;

  // Receiver state
  logic             rx_meta;
  logic             rx_sync;
  state_t           rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_shift;

  // Receive FIFO
  logic [7:0]       fifo_mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       fifo_cnt;
  logic             ack_hold;

  logic             stop_hit;
  logic             push_req;
  logic             frame_bad;
  logic             ack_ok;
  logic             push_ok;

  // Stop bit is judged on the same edge the RX FSM leaves STOP.
  assign stop_hit  = (rx_state == STOP) && (rx_cnt == BIT_LAST);
  assign push_req  = stop_hit && rx_sync;
  assign frame_bad = stop_hit && !rx_sync;
  assign ack_ok    = rx_ack && rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok   = push_req && ((fifo_cnt != 2'd2) || ack_ok);

  assign rx_ready  = (fifo_cnt != 2'd0) && !ack_hold;
  assign rx_data   = fifo_mem[rd_ptr];

  // TX FSM: serializes start, 8 data bits LSB first and stop, each bit held CLKS_PER_BIT clocks
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_shift <= tx_data;
            tx_cnt   <= '0;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx       <= tx_shift[0];
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_ready <= 1'b1;
            tx_state <= IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous rx line (idles high)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // RX FSM: validates the start bit at half-bit, then samples each bit at mid-bit
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        IDLE: begin
          if (!rx_sync) begin
            rx_cnt   <= '0;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_sync ? IDLE : DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_idx == 3'd7) begin
              rx_state <= STOP;
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // Receive FIFO, one-cycle rx_ready blanking after an accepted ack, sticky error flags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_cnt    <= '0;
      ack_hold    <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      ack_hold <= ack_ok;
      if (push_ok) begin
        fifo_mem[wr_ptr] <= rx_shift;
        wr_ptr           <= ~wr_ptr;
      end
      if (ack_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, ack_ok})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      err_frame   <= (err_frame && !ack_ok) || frame_bad;
      err_overrun <= (err_overrun && !ack_ok) || (push_req && !push_ok);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart
//  Purpose  : loopback bench for uart with a queue-based receive model
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart;

  // Short bit period keeps the run small: 13 clocks per bit, half-bit 6.
  localparam int CLK_FREQ = 1_497_600;
  localparam int BAUD     = 115200;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ack;
  logic       err_frame;
  logic       err_overrun;

  logic       loop;
  logic       rx_drv;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the receive side
  logic [7:0] q[$];
  bit         m_ef;
  bit         m_eo;

  always #4 clk = ~clk;

  assign rx = loop ? tx : rx_drv;

  uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rx_ack     (rx_ack),
    .err_frame  (err_frame),
    .err_overrun(err_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level of bit slot j (0 = start, 1..8 = data LSB first, 9 = stop)
  function automatic logic exp_line(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return b[j-1];
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (q.size() < 2) q.push_back(b);
    else              m_eo = 1'b1;
  endfunction

  task automatic check_rx();
    check("rx_ready", 32'(rx_ready), 32'(q.size() != 0));
    if (q.size() != 0) check("rx_data", 32'(rx_data), 32'(q[0]));
    check("err_frame", 32'(err_frame), 32'(m_ef));
    check("err_overrun", 32'(err_overrun), 32'(m_eo));
  endtask

  // Sends one byte and checks the tx line every clock of the frame.
  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    while (!tx_ready && guard < 20*CPB) begin
      @(negedge clk);
      guard++;
    end
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 10*CPB; k++) begin
      @(negedge clk);
      if (k < 10*CPB-1) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
      end else begin
        tx_valid = 1'b0;
      end
      if (k < 10*CPB) begin
        check("tx_line", 32'(tx), 32'(exp_line(b, k / CPB)));
        check("tx_busy", 32'(tx_ready), 32'd0);
      end else begin
        check("tx_idle_line", 32'(tx), 32'd1);
        check("tx_ready_back", 32'(tx_ready), 32'd1);
      end
    end
    if (loop) model_push(b);
  endtask

  task automatic ack();
    bit acc;
    acc    = (q.size() != 0);
    rx_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_ack = 1'b0;
    if (acc) begin
      void'(q.pop_front());
      m_ef = 1'b0;
      m_eo = 1'b0;
      check("ack_hold", 32'(rx_ready), 32'd0);
      @(negedge clk);
    end
    check_rx();
  endtask

  // Bit-bangs a frame on rx with a chosen stop level.
  task automatic drive_frame(input logic [7:0] b, input logic stop);
    loop = 1'b0;
    for (int j = 0; j < 10; j++) begin
      rx_drv = (j == 9) ? stop : exp_line(b, j);
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2*CPB) @(negedge clk);
    if (stop) model_push(b);
    else      m_ef = 1'b1;
    check_rx();
    loop = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_err_frame", 32'(err_frame), 32'd0);
    check("rst_err_overrun", 32'(err_overrun), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    resetn   = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ack   = 1'b0;
    loop     = 1'b1;
    rx_drv   = 1'b1;
    m_ef     = 1'b0;
    m_eo     = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs();
    resetn = 1'b1;
    @(negedge clk);

    // Single frames
    send(8'h55); check_rx(); ack();
    send(8'hA3); check_rx(); ack();

    // Back-to-back pair, no ack in between
    send(8'h12); send(8'h34); check_rx();
    ack(); ack();

    // Overrun on the third unacked frame
    send(8'h01); send(8'h02); send(8'h03); check_rx();
    ack(); ack();

    // Framing error, ignored ack, short glitch, then a clean frame
    drive_frame(8'($urandom), 1'b0);
    ack();
    loop   = 1'b0;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12*CPB) @(negedge clk);
    check_rx();
    loop = 1'b1;
    drive_frame(8'hC7, 1'b1);
    ack();

    // Randomized traffic with random ack patterns
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 5) == 0) drive_frame(b, 1'($urandom_range(0, 1)));
      else begin
        send(b);
        check_rx();
      end
      case ($urandom_range(0, 3))
        0:       ;
        1, 2:    ack();
        default: begin ack(); ack(); end
      endcase
    end

    // Reset in the middle of a transmit frame
    send(8'h9E);
    tx_data  = 8'($urandom);
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (4*CPB + 3) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    resetn = 1'b1;
    q.delete();
    m_ef = 1'b0;
    m_eo = 1'b0;
    @(negedge clk);
    send(8'($urandom)); check_rx(); ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
